accumulate_controller: RTL and testbench

Sequencer for the lab accumulator datapath. It synchronises the active-low `Run_Accumulate` push-button and turns each press into exactly one add of `SW` into the running sum `S`. It drives an external adder (ripple, lookahead or select; any latency) through a start/done handshake and owns the 17-bit accumulator register. It sits between the board I/O and the adder inside the adder top level.

---
 rtl/accumulate_controller.sv | 97 +++++++++
 tb/tb_accumulate_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/accumulate_controller.sv
// accumulate_controller: turns each press of the active-low Run_Accumulate button into one add of SW into S
// Ports: Clk, Reset_Clear (sync, active-low), Run_Accumulate (raw button), SW (addend);
//   adder handshake add_start/add_a/add_b out, add_done/add_sum in; S accumulator, cout = S[WIDTH],
//   busy (not IDLE), err (sticky adder timeout).
// Optional: define ACCUM_CTRL_DEBOUNCE_EN to filter the synchronised button for DEBOUNCE_CYCLES samples.
module accumulate_controller #(
  parameter int WIDTH           = 16,
  parameter int SW_WIDTH        = 10,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic               Clk,
  input  logic               Reset_Clear,
  input  logic               Run_Accumulate,
  input  logic [SW_WIDTH-1:0] SW,
  output logic               add_start,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic               add_done,
  input  logic [WIDTH:0]     add_sum,
  output logic [WIDTH:0]     S,
  output logic               cout,
  output logic               busy,
  output logic               err
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, ADD = 2'd2, HOLD = 2'd3;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] state;
  logic s1, s2, lvl, lvl_q, press, released;
  logic [TW-1:0] tcnt;
`ifdef ACCUM_CTRL_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DW-1:0] dcnt;
  logic filt;
  // Any sample matching the filtered level restarts the run count, so only an unbroken run flips it.
  always_ff @(posedge Clk) begin
    if (!Reset_Clear) begin
      dcnt <= '0;
      filt <= 1'b1;
    end else if (s2 == filt) begin
      dcnt <= '0;
    end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      dcnt <= '0;
      filt <= s2;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end
  assign lvl = filt;
`else
  assign lvl = s2;
`endif
  assign press     = lvl_q & ~lvl;
  assign released  = lvl;
  assign add_start = state == LOAD;
  assign busy      = state != IDLE;
  assign add_a     = S[WIDTH-1:0];
  assign cout      = S[WIDTH];
  always_ff @(posedge Clk) begin
    if (!Reset_Clear) begin
      state <= IDLE;
      S     <= '0;
      err   <= 1'b0;
      add_b <= '0;
      tcnt  <= '0;
      s1    <= 1'b1;
      s2    <= 1'b1;
      lvl_q <= 1'b1;
    end else begin
      s1    <= Run_Accumulate;
      s2    <= s1;
      lvl_q <= lvl;
      case (state)
        IDLE: if (press) begin
          state <= LOAD;
          add_b <= WIDTH'(SW);
          err   <= 1'b0;
        end
        LOAD: begin
          state <= ADD;
          tcnt  <= '0;
        end
        // tcnt counts completed ADD cycles; the edge that would make it TIMEOUT_CYCLES gives up.
        ADD: if (add_done) begin
          S     <= add_sum;
          state <= HOLD;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          err   <= 1'b1;
          state <= HOLD;
        end else begin
          tcnt  <= tcnt + 1'b1;
        end
        HOLD: if (released) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accumulate_controller.sv
// tb_accumulate_controller: directed and random presses against a behavioural accumulator model
module tb_accumulate_controller;
  localparam int TO = 64;
`ifdef ACCUM_CTRL_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  logic Clk = 1'b0, Reset_Clear = 1'b0, Run_Accumulate = 1'b1;
  logic [9:0] SW = '0;
  logic add_start, add_done, cout, busy, err;
  logic [15:0] add_a, add_b;
  logic [16:0] add_sum, S;
  logic tied = 1'b1, force_on = 1'b0, hang = 1'b0, done_r = 1'b0;
  logic [16:0] force_val = '0;
  int lat = 0, cnt = 0, starts = 0, compared = 0, mism = 0;
  int ref_s = 0;

  accumulate_controller dut (
    .Clk(Clk), .Reset_Clear(Reset_Clear), .Run_Accumulate(Run_Accumulate), .SW(SW),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_done(add_done),
    .add_sum(add_sum), .S(S), .cout(cout), .busy(busy), .err(err)
  );

  always #5 Clk = ~Clk;

  // Adder model: either tied-high combinational, or a done pulse lat cycles after the start request.
  assign add_done = tied ? 1'b1 : done_r;
  assign add_sum  = force_on ? force_val : {1'b0, add_a} + {1'b0, add_b};

  always @(posedge Clk) if (add_start) starts = starts + 1;

  always @(negedge Clk) begin
    done_r = 1'b0;
    if (add_start) cnt = lat;
    else if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) done_r = !hang;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!add_start && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 200) check("start_timeout", 32'(add_start), 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 500) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 500) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic set_adder(input int l);
    tied = (l == 0);
    lat  = l;
  endtask

  task automatic press(input logic [9:0] sw);
    int n;
    SW = sw;
    Run_Accumulate = 1'b0;
    repeat (4 + DB) @(negedge Clk);
    Run_Accumulate = 1'b1;
    wait_idle(n);
    ref_s = (ref_s % 65536) + int'(sw);
  endtask

  task automatic do_reset();
    Reset_Clear = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_Clear = 1'b1;
    ref_s = 0;
  endtask

  initial begin
    int n, s0, sv;
    @(negedge Clk);
    do_reset();
    repeat (5) @(negedge Clk);
    check("rst_S", 32'(S), 32'h0);
    check("rst_cout", 32'(cout), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_add_b", 32'(add_b), 32'h0);
    check("rst_starts", 32'(starts), 32'h0);

    press(10'h0A9);
    check("acc1_S", 32'(S), 32'h000A9);
    press(10'h0C5);
    check("acc2_S", 32'(S), 32'h0016E);
    check("acc2_cout", 32'(cout), 32'h0);
    check("acc2_starts", 32'(starts), 32'd2);
    check("acc2_ref", 32'(S), 32'(ref_s));

    // Held button: measure press and release latency too.
    s0 = starts;
    SW = 10'h001;
    Run_Accumulate = 1'b0;
    wait_start(n);
    check("press_latency", 32'(n), 32'(3 + DB));
    repeat (50 - n) @(negedge Clk);
    Run_Accumulate = 1'b1;
    wait_idle(n);
    check("release_latency", 32'(n), 32'(3 + DB));
    ref_s = (ref_s % 65536) + 1;
    check("held_S", 32'(S), 32'(ref_s));
    check("held_starts", 32'(starts - s0), 32'd1);

    // Re-pressing during a slow add must not start another add.
    s0 = starts;
    set_adder(10);
    SW = 10'h007;
    Run_Accumulate = 1'b0;
    wait_start(n);
    Run_Accumulate = 1'b1;
    repeat (2) @(negedge Clk);
    Run_Accumulate = 1'b0;
    repeat (2) @(negedge Clk);
    Run_Accumulate = 1'b1;
    wait_idle(n);
    repeat (5 + DB) @(negedge Clk);
    ref_s = (ref_s % 65536) + 7;
    check("pulse_S", 32'(S), 32'(ref_s));
    check("pulse_starts", 32'(starts - s0), 32'd1);

    // Wrap and carry.
    set_adder(0);
    do_reset();
    @(negedge Clk);
    for (int i = 0; i < 65; i++) press(10'h3FF);
    check("wrap_S", 32'(S), 32'h103BF);
    check("wrap_low", 32'(S[15:0]), 32'h03BF);
    check("wrap_cout", 32'(cout), 32'h1);
    press(10'h001);
    check("wrap2_S", 32'(S), 32'h003C0);
    check("wrap2_cout", 32'(cout), 32'h0);

    // Random presses with random adder latency.
    for (int i = 0; i < 20; i++) begin
      set_adder(int'($urandom_range(0, 6)));
      s0 = starts;
      press(10'($urandom));
      check("rand_S", 32'(S), 32'(ref_s));
      check("rand_starts", 32'(starts - s0), 32'd1);
    end

    // Timeout.
    sv = int'(S);
    set_adder(5);
    hang = 1'b1;
    Run_Accumulate = 1'b0;
    wait_start(n);
    n = 0;
    while (!err && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TO + 1));
    check("timeout_S", 32'(S), 32'(sv));
    check("timeout_busy", 32'(busy), 32'd1);
    Run_Accumulate = 1'b1;
    wait_idle(n);
    check("timeout_idle", 32'(busy), 32'd0);
    check("timeout_err_sticky", 32'(err), 32'd1);
    hang = 1'b0;
    set_adder(3);
    press(10'h055);
    check("err_cleared", 32'(err), 32'd0);
    check("after_err_S", 32'(S), 32'(ref_s));

    // Reset during ADD; the late add_done must be ignored.
    set_adder(10);
    force_on = 1'b1;
    force_val = 17'h1FFFF;
    Run_Accumulate = 1'b0;
    wait_start(n);
    repeat (3) @(negedge Clk);
    Reset_Clear = 1'b0;
    @(negedge Clk);
    Reset_Clear = 1'b1;
    Run_Accumulate = 1'b1;
    ref_s = 0;
    repeat (15) @(negedge Clk);
    check("midrst_S", 32'(S), 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    force_on = 1'b0;
    set_adder(0);
    press(10'h123);
    check("post_rst_S", 32'(S), 32'(ref_s));

`ifdef ACCUM_CTRL_DEBOUNCE_EN
    s0 = starts;
    Run_Accumulate = 1'b0;
    repeat (5) @(negedge Clk);
    Run_Accumulate = 1'b1;
    repeat (40) @(negedge Clk);
    check("glitch_starts", 32'(starts - s0), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
